load_store_unit: RTL and testbench

Pipeline-side initiator for the byte-addressed data memory. It accepts one load or store command at a time from the MEM stage and decodes RISC-V funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW) into the memory's MemRead/MemWrite/HalfOperation/ByteOperation strobes. It absorbs the memory's one-cycle registered read latency and sign- or zero-extends load data. Misaligned, out-of-range and illegal accesses are flagged as faults and never reach the memory.

---
 rtl/load_store_unit.sv | 145 ++++++++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator for the byte-addressed data memory: decodes funct3 into
// memory strobes, rejects illegal accesses and extends load data.
module load_store_unit #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_half,
  output logic        mem_byte,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: a command transfers on a rising edge where req_valid & req_ready;
  // the source holds it stable until then. resp_valid is a one-cycle pulse.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]  state;
  logic [2:0]  lat_funct3;
  logic        lat_is_store;
  logic [4:0]  lat_rd;

  logic [2:0]  acc_size;
  logic        bad_funct3;
  logic        misaligned;
  logic [32:0] end_addr;
  logic        out_of_range;
  logic        req_fault;
  logic [31:0] load_ext;

  assign req_ready = (state == IDLE) && !rst;
  assign dbg_state = state;

  always_comb begin
    acc_size = 3'd1;
    case (req_funct3[1:0])
      2'b01:   acc_size = 3'd2;
      2'b10:   acc_size = 3'd4;
      default: acc_size = 3'd1;
    endcase
    if (req_is_store) bad_funct3 = (req_funct3 > 3'b010);
    else              bad_funct3 = (req_funct3 inside {3'b011, 3'b110, 3'b111});
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    end_addr     = {1'b0, req_addr} + {30'd0, acc_size};
    out_of_range = end_addr > 33'(MEM_BYTES);
    req_fault    = bad_funct3 || misaligned || out_of_range;
  end

  always_comb begin
    case (lat_funct3)
      3'b000:  load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_funct3   <= 3'd0;
      lat_is_store <= 1'b0;
      lat_rd       <= 5'd0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'd0;
      resp_rd      <= 5'd0;
      resp_fault   <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_half     <= 1'b0;
      mem_byte     <= 1'b0;
    end else begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_half   <= 1'b0;
      mem_byte   <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_funct3   <= req_funct3;
            lat_is_store <= req_is_store;
            lat_rd       <= req_rd;
            mem_addr     <= req_addr;
            mem_wdata    <= req_wdata;
            if (req_fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= 32'd0;
              resp_rd    <= req_rd;
            end else begin
              state     <= ACCESS;
              mem_read  <= ~req_is_store;
              mem_write <= req_is_store;
              mem_byte  <= (req_funct3[1:0] == 2'b00);
              mem_half  <= (req_funct3[1:0] == 2'b01);
            end
          end
        end
        ACCESS: begin
          if (lat_is_store) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= 32'd0;
            resp_rd    <= lat_rd;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_rdata <= load_ext;
          resp_rd    <= lat_rd;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural byte memory with one-cycle read latency,
// scoreboard of expected responses, directed and random load/store commands.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic        mem_half;
  logic        mem_byte;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  logic [7:0]  mem [0:255];
  wire  [7:0]  ma = mem_addr[7:0];

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;
  int wr_cnt  = 0;
  int both_cnt = 0;
  logic [37:0] exp_q[$];

  load_store_unit #(.MEM_BYTES(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_half(mem_half), .mem_byte(mem_byte), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0] <= 8'hFF; mem[1] <= 8'h54; mem[2] <= 8'h01; mem[3] <= 8'h02;
      mem[6] <= 8'h10; mem[7] <= 8'h82;
      mem[20] <= 8'h5A; mem[21] <= 8'h6B; mem[22] <= 8'h7C; mem[23] <= 8'h8D;
      mem_rdata <= 32'd0;
    end else begin
      if (mem_write) begin
        mem[ma] <= mem_wdata[7:0];
        if (!mem_byte) mem[ma + 8'd1] <= mem_wdata[15:8];
        if (!mem_byte && !mem_half) begin
          mem[ma + 8'd2] <= mem_wdata[23:16];
          mem[ma + 8'd3] <= mem_wdata[31:24];
        end
      end
      if (mem_read) begin
        if (mem_byte)      mem_rdata <= {24'd0, mem[ma]};
        else if (mem_half) mem_rdata <= {16'd0, mem[ma + 8'd1], mem[ma]};
        else mem_rdata <= {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=done");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0]  i;
    logic [31:0] w;
    i = a[7:0];
    w = {mem[i + 8'd3], mem[i + 8'd2], mem[i + 8'd1], mem[i]};
    case (f3)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd2:    return w;
      3'd4:    return {24'd0, w[7:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (mem_read)  rd_cnt++;
    if (mem_write) wr_cnt++;
    if (mem_read && mem_write) both_cnt++;
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) check("resp_unexpected", 64'd1, 64'd0);
      else check("resp", {26'd0, resp_fault, resp_rd, resp_rdata}, {26'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver ----------------
  task automatic run_cmd(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic exp_fault, input logic [31:0] exp_data);
    int n;
    int rd0;
    int wr0;
    bit got;
    @(posedge clk); #1;
    exp_q.push_back({exp_fault, rd, (exp_fault || st) ? 32'd0 : exp_data});
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    check("accept", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    n = 0;
    for (int k = 1; k <= 10 && n == 0; k++) begin
      @(negedge clk);
      if (resp_valid) n = k;
    end
    check("latency", 64'(n), exp_fault ? 64'd1 : (st ? 64'd2 : 64'd3));
    @(negedge clk);
    check("ready_after", 64'(req_ready), 64'd1);
    check("resp_pulse", 64'(resp_valid), 64'd0);
    check("rd_strobes", 64'(rd_cnt - rd0), (exp_fault || st) ? 64'd0 : 64'd1);
    check("wr_strobes", 64'(wr_cnt - wr0), (!exp_fault && st) ? 64'd1 : 64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [2:0]  load_f3_tab [0:4];
  logic [2:0]  rf3;
  logic [31:0] raddr;
  logic        rst_st;

  initial begin
    load_f3_tab[0] = 3'd0; load_f3_tab[1] = 3'd1; load_f3_tab[2] = 3'd2;
    load_f3_tab[3] = 3'd4; load_f3_tab[4] = 3'd5;
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_outs", {21'd0, resp_valid, resp_fault, resp_rd, resp_rdata,
                       mem_read, mem_write, mem_half, mem_byte}, 64'd0);
    check("rst_mem_bus", {mem_addr, mem_wdata}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_post_rst", 64'(req_ready), 64'd1);

    // preloaded loads
    run_cmd(1'b0, 3'd2, 32'd0, 32'd0, 5'd1, 1'b0, 32'h020154FF);
    run_cmd(1'b0, 3'd0, 32'd0, 32'd0, 5'd2, 1'b0, 32'hFFFFFFFF);
    run_cmd(1'b0, 3'd4, 32'd0, 32'd0, 5'd3, 1'b0, 32'h000000FF);
    run_cmd(1'b0, 3'd1, 32'd6, 32'd0, 5'd4, 1'b0, 32'hFFFF8210);
    run_cmd(1'b0, 3'd5, 32'd6, 32'd0, 5'd5, 1'b0, 32'h00008210);

    // store then partial loads
    run_cmd(1'b1, 3'd2, 32'd16, 32'h11223344, 5'd6, 1'b0, 32'd0);
    run_cmd(1'b0, 3'd1, 32'd18, 32'd0, 5'd7, 1'b0, 32'h00001122);
    run_cmd(1'b0, 3'd0, 32'd19, 32'd0, 5'd8, 1'b0, 32'h00000011);
    run_cmd(1'b1, 3'd0, 32'd20, 32'hAABBCCDD, 5'd9, 1'b0, 32'd0);
    run_cmd(1'b0, 3'd4, 32'd20, 32'd0, 5'd10, 1'b0, 32'h000000DD);
    check("sb_neighbours", {40'd0, mem[23], mem[22], mem[21]}, {40'd0, 24'h8D7C6B});

    // faults and range boundaries
    run_cmd(1'b0, 3'd2, 32'd2,   32'd0, 5'd11, 1'b1, 32'd0);
    run_cmd(1'b0, 3'd1, 32'd5,   32'd0, 5'd12, 1'b1, 32'd0);
    run_cmd(1'b0, 3'd2, 32'd254, 32'd0, 5'd13, 1'b1, 32'd0);
    run_cmd(1'b1, 3'd3, 32'd0,   32'd0, 5'd14, 1'b1, 32'd0);
    run_cmd(1'b0, 3'd3, 32'd0,   32'd0, 5'd15, 1'b1, 32'd0);
    run_cmd(1'b0, 3'd6, 32'd0,   32'd0, 5'd16, 1'b1, 32'd0);
    run_cmd(1'b1, 3'd4, 32'd0,   32'd0, 5'd17, 1'b1, 32'd0);
    run_cmd(1'b0, 3'd0, 32'd256, 32'd0, 5'd18, 1'b1, 32'd0);
    run_cmd(1'b0, 3'd4, 32'd255, 32'd0, 5'd19, 1'b0, 32'd0);
    run_cmd(1'b0, 3'd2, 32'd252, 32'd0, 5'd20, 1'b0, 32'd0);

    // random aligned traffic in 32..63
    repeat (16) begin
      rst_st = 1'($urandom_range(0, 1));
      rf3 = rst_st ? 3'($urandom_range(0, 2)) : load_f3_tab[$urandom_range(0, 4)];
      raddr = 32'($urandom_range(32, 60));
      if (rf3[1:0] == 2'b01) raddr[0] = 1'b0;
      if (rf3[1:0] == 2'b10) raddr[1:0] = 2'b00;
      run_cmd(rst_st, rf3, raddr, $urandom, 5'($urandom_range(0, 31)), 1'b0,
              rst_st ? 32'd0 : ref_load(rf3, raddr));
    end

    // reset while a load waits for data
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'd0; req_rd = 5'd7;
    @(negedge clk);
    check("rst_test_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_in_wait_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_outs", {21'd0, resp_valid, resp_fault, resp_rd, resp_rdata,
                           mem_read, mem_write, mem_half, mem_byte}, 64'd0);
    check("mid_rst_mem_bus", {mem_addr, mem_wdata}, 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    run_cmd(1'b0, 3'd2, 32'd0, 32'd0, 5'd21, 1'b0, 32'h020154FF);

    repeat (3) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("strobe_overlap", 64'(both_cnt), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
